// File: rtl/load_sequencer_if.sv
// Command/strobe bundle between a DMA decoder (master) and load_sequencer (slave).
interface load_sequencer_if;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;

  logic              fetch_w;
  logic              fetch_inp;
  logic              fetch_ins;
  logic              start;
  logic [ADDR_W-1:0] dma_address;
  logic [DATA_W-1:0] data_in;
  logic              compute_done;

  logic              w_we;
  logic              inp_we;
  logic              ins_we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              compute_start;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output fetch_w, fetch_inp, fetch_ins, start, dma_address, data_in, compute_done,
    input  w_we, inp_we, ins_we, wr_addr, wr_data, compute_start, busy, done, err
  );

  modport slave (
    input  fetch_w, fetch_inp, fetch_ins, start, dma_address, data_in, compute_done,
    output w_we, inp_we, ins_we, wr_addr, wr_data, compute_start, busy, done, err
  );
endinterface

// File: rtl/load_sequencer.sv
// Loads weight/input/instruction memories, then launches and tracks one array run.
// Optional sticky error flag enabled by defining LOAD_SEQ_ERR_EN.
module load_sequencer #(
  parameter int unsigned W_WORDS   = 4,
  parameter int unsigned INP_WORDS = 4,
  parameter int unsigned INS_WORDS = 8
) (
  input  logic             clk,
  input  logic             reset,
  load_sequencer_if.slave  bus
);
  localparam int unsigned MASK_W = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;

  localparam logic [MASK_W-1:0] W_NEED   = MASK_W'((33'd1 << W_WORDS) - 33'd1);
  localparam logic [MASK_W-1:0] INP_NEED = MASK_W'((33'd1 << INP_WORDS) - 33'd1);
  localparam logic [MASK_W-1:0] INS_NEED = MASK_W'((33'd1 << INS_WORDS) - 33'd1);

  typedef enum logic [1:0] {IDLE, START, WAIT, FINISH} state_t;

  state_t            state;
  logic [MASK_W-1:0] w_mask;
  logic [MASK_W-1:0] inp_mask;
  logic [MASK_W-1:0] ins_mask;
  logic              w_we;
  logic              inp_we;
  logic              ins_we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              compute_start;
  logic              busy;
  logic              done;

  logic              regions_full_c;
  logic [MASK_W-1:0] addr_bit_c;

  // Only the low X_WORDS bits of each mask gate a run.
  assign regions_full_c = ((w_mask   & W_NEED)   == W_NEED)   &&
                          ((inp_mask & INP_NEED) == INP_NEED) &&
                          ((ins_mask & INS_NEED) == INS_NEED);
  assign addr_bit_c     = MASK_W'(1) << bus.dma_address;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      w_mask        <= '0;
      inp_mask      <= '0;
      ins_mask      <= '0;
      w_we          <= 1'b0;
      inp_we        <= 1'b0;
      ins_we        <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      compute_start <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      w_we          <= 1'b0;
      inp_we        <= 1'b0;
      ins_we        <= 1'b0;
      compute_start <= 1'b0;
      done          <= 1'b0;
      case (state)
        // Fixed priority: weights, inputs, instructions, then start.
        IDLE: begin
          if (bus.fetch_w) begin
            w_we    <= 1'b1;
            wr_addr <= bus.dma_address;
            wr_data <= bus.data_in;
            w_mask  <= w_mask | addr_bit_c;
          end else if (bus.fetch_inp) begin
            inp_we   <= 1'b1;
            wr_addr  <= bus.dma_address;
            wr_data  <= bus.data_in;
            inp_mask <= inp_mask | addr_bit_c;
          end else if (bus.fetch_ins) begin
            ins_we   <= 1'b1;
            wr_addr  <= bus.dma_address;
            wr_data  <= bus.data_in;
            ins_mask <= ins_mask | addr_bit_c;
          end else if (bus.start && regions_full_c) begin
            state         <= START;
            compute_start <= 1'b1;
            busy          <= 1'b1;
          end
        end
        START: state <= WAIT;
        // Masks clear on entry to FINISH so a held start cannot relaunch.
        WAIT: begin
          if (bus.compute_done) begin
            state    <= FINISH;
            done     <= 1'b1;
            busy     <= 1'b0;
            w_mask   <= '0;
            inp_mask <= '0;
            ins_mask <= '0;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LOAD_SEQ_ERR_EN
  logic [3:0] cmds_c;
  logic       multi_cmd_c;
  logic       fetch_c;
  logic       err_set_c;
  logic       err;

  assign cmds_c      = {bus.fetch_w, bus.fetch_inp, bus.fetch_ins, bus.start};
  assign multi_cmd_c = (cmds_c & 4'(cmds_c - 4'd1)) != 4'd0;
  assign fetch_c     = bus.fetch_w | bus.fetch_inp | bus.fetch_ins;
  assign err_set_c   = multi_cmd_c ||
                       ((state != IDLE) && fetch_c) ||
                       ((state == IDLE) && bus.start && !fetch_c && !regions_full_c);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          err <= 1'b0;
    else if (err_set_c) err <= 1'b1;
  end

  assign bus.err = err;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.w_we          = w_we;
  assign bus.inp_we        = inp_we;
  assign bus.ins_we        = ins_we;
  assign bus.wr_addr       = wr_addr;
  assign bus.wr_data       = wr_data;
  assign bus.compute_start = compute_start;
  assign bus.busy          = busy;
  assign bus.done          = done;
endmodule

// File: tb/tb_load_sequencer.sv
// Directed bench for load_sequencer: load, launch, finish, reject, abort cases.
module tb_load_sequencer;
  localparam int unsigned W_WORDS   = 4;
  localparam int unsigned INP_WORDS = 4;
  localparam int unsigned INS_WORDS = 8;
`ifdef LOAD_SEQ_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif
  localparam logic [31:0] S_IDLE = 32'd0, S_START = 32'd1, S_WAIT = 32'd2, S_FINISH = 32'd3;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  load_sequencer_if bus ();

  load_sequencer #(
    .W_WORDS   (W_WORDS),
    .INP_WORDS (INP_WORDS),
    .INS_WORDS (INS_WORDS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_cmds();
    bus.fetch_w      = 1'b0;
    bus.fetch_inp    = 1'b0;
    bus.fetch_ins    = 1'b0;
    bus.start        = 1'b0;
    bus.compute_done = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_cmds();
    bus.dma_address = '0;
    bus.data_in     = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One command cycle; region 0=weights, 1=inputs, 2=instructions.
  task automatic do_fetch(input int region, input logic [3:0] a, input logic [7:0] d,
                          input logic exp_we, input string tag);
    bus.fetch_w     = (region == 0);
    bus.fetch_inp   = (region == 1);
    bus.fetch_ins   = (region == 2);
    bus.dma_address = a;
    bus.data_in     = d;
    @(negedge clk);
    clear_cmds();
    check({tag, "_w_we"},   32'(bus.w_we),   32'(exp_we && region == 0));
    check({tag, "_inp_we"}, 32'(bus.inp_we), 32'(exp_we && region == 1));
    check({tag, "_ins_we"}, 32'(bus.ins_we), 32'(exp_we && region == 2));
    if (exp_we) begin
      check({tag, "_addr"}, 32'(bus.wr_addr), 32'(a));
      check({tag, "_data"}, 32'(bus.wr_data), 32'(d));
    end
  endtask

  task automatic load_all();
    for (int i = 0; i < W_WORDS; i++)   do_fetch(0, 4'(i), 8'(i + 16), 1'b1, "ld_w");
    for (int i = 0; i < INP_WORDS; i++) do_fetch(1, 4'(i), 8'(i + 16), 1'b1, "ld_inp");
    for (int i = 0; i < INS_WORDS; i++) do_fetch(2, 4'(i), 8'(i + 16), 1'b1, "ld_ins");
  endtask

  task automatic launch(input string tag);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_cs_hi"},  32'(bus.compute_start), 32'd1);
    check({tag, "_busy"},   32'(bus.busy),          32'd1);
    check({tag, "_st_start"}, 32'(dut.state),       S_START);
    @(negedge clk);
    check({tag, "_cs_lo"},  32'(bus.compute_start), 32'd0);
    check({tag, "_st_wait"}, 32'(dut.state),        S_WAIT);
  endtask

  task automatic try_reject(input string tag, input logic exp_err);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_cs"},   32'(bus.compute_start), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy),          32'd0);
    check({tag, "_st"},   32'(dut.state),         S_IDLE);
    check({tag, "_err"},  32'(bus.err),           32'(exp_err));
  endtask

  initial begin
    reset = 1'b1;
    clear_cmds();
    bus.dma_address = '0;
    bus.data_in     = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_w_we",   32'(bus.w_we),          32'd0);
    check("rst_inp_we", 32'(bus.inp_we),        32'd0);
    check("rst_ins_we", 32'(bus.ins_we),        32'd0);
    check("rst_addr",   32'(bus.wr_addr),       32'd0);
    check("rst_data",   32'(bus.wr_data),       32'd0);
    check("rst_cs",     32'(bus.compute_start), 32'd0);
    check("rst_busy",   32'(bus.busy),          32'd0);
    check("rst_done",   32'(bus.done),          32'd0);
    check("rst_err",    32'(bus.err),           32'd0);
    check("rst_state",  32'(dut.state),         S_IDLE);
    reset = 1'b0;

    // compute_done outside WAIT is ignored
    bus.compute_done = 1'b1;
    @(negedge clk);
    bus.compute_done = 1'b0;
    check("idle_cdone_done", 32'(bus.done), 32'd0);
    check("idle_cdone_st",   32'(dut.state), S_IDLE);

    // Full load and launch
    load_all();
    launch("run1");
    check("run1_err", 32'(bus.err), 32'd0);

    // Finish, with start held across FINISH->IDLE
    bus.compute_done = 1'b1;
    @(negedge clk);
    bus.compute_done = 1'b0;
    bus.start        = 1'b1;
    check("fin_done",  32'(bus.done),  32'd1);
    check("fin_busy",  32'(bus.busy),  32'd0);
    check("fin_state", 32'(dut.state), S_FINISH);
    check("fin_wmask", 32'(dut.w_mask), 32'd0);
    @(negedge clk);
    check("post_done",  32'(bus.done),  32'd0);
    check("post_state", 32'(dut.state), S_IDLE);
    check("post_cs",    32'(bus.compute_start), 32'd0);
    try_reject("relaunch", ERR_EN);

    // Incomplete weights: 0..2 only, plus an out-of-range word 5
    do_reset();
    for (int i = 0; i < 3; i++)         do_fetch(0, 4'(i), 8'(i + 16), 1'b1, "pw");
    for (int i = 0; i < INP_WORDS; i++) do_fetch(1, 4'(i), 8'(i + 16), 1'b1, "pi");
    for (int i = 0; i < INS_WORDS; i++) do_fetch(2, 4'(i), 8'(i + 16), 1'b1, "ps");
    try_reject("partial", ERR_EN);
    do_fetch(0, 4'd5, 8'h55, 1'b1, "w5");
    try_reject("w5_only", ERR_EN);
    do_fetch(0, 4'd3, 8'h13, 1'b1, "w3");
    launch("late");
    do_reset();

    // Fetch during WAIT is dropped
    load_all();
    launch("run2");
    do_fetch(0, 4'd5, 8'h55, 1'b0, "wait_fw");
    check("wait_fw_mask", 32'(dut.w_mask),  32'h000F);
    check("wait_fw_addr", 32'(bus.wr_addr), 32'd7);
    check("wait_fw_data", 32'(bus.wr_data), 32'h17);
    check("wait_fw_err",  32'(bus.err),     32'(ERR_EN));
    do_reset();

    // fetch_w beats start; fetch_inp beats fetch_ins
    load_all();
    bus.fetch_w = 1'b1; bus.start = 1'b1; bus.dma_address = 4'd2; bus.data_in = 8'hA2;
    @(negedge clk);
    clear_cmds();
    check("prio_w_we",   32'(bus.w_we),          32'd1);
    check("prio_w_addr", 32'(bus.wr_addr),       32'd2);
    check("prio_w_data", 32'(bus.wr_data),       32'hA2);
    check("prio_cs",     32'(bus.compute_start), 32'd0);
    check("prio_st",     32'(dut.state),         S_IDLE);
    check("prio_err",    32'(bus.err),           32'(ERR_EN));
    bus.fetch_inp = 1'b1; bus.fetch_ins = 1'b1; bus.dma_address = 4'd9; bus.data_in = 8'h39;
    @(negedge clk);
    clear_cmds();
    check("prio_inp_we", 32'(bus.inp_we), 32'd1);
    check("prio_ins_we", 32'(bus.ins_we), 32'd0);
    check("prio_inp_addr", 32'(bus.wr_addr), 32'd9);
    launch("run3");

    // Async reset mid-WAIT, then a stale compute_done
    reset = 1'b1;
    #1;
    check("abort_busy",  32'(bus.busy),  32'd0);
    check("abort_state", 32'(dut.state), S_IDLE);
    @(negedge clk);
    reset = 1'b0;
    bus.compute_done = 1'b1;
    @(negedge clk);
    bus.compute_done = 1'b0;
    check("abort_done",  32'(bus.done),          32'd0);
    check("abort_cs",    32'(bus.compute_start), 32'd0);
    check("abort_err",   32'(bus.err),           32'd0);
    check("abort_st",    32'(dut.state),         S_IDLE);
    check("abort_masks", 32'(dut.w_mask | dut.inp_mask | dut.ins_mask), 32'd0);
    @(negedge clk);
    check("abort_done2", 32'(bus.done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, tests run %0d", n_tests);
    $fatal(1);
  end
endmodule

// File: doc/load_sequencer.md
LOAD_SEQUENCER -- requirements
Module: load_sequencer

Interface
REQ-001 Parameter W_WORDS, default 4: number of weight words that must be loaded before a run (1..16).
REQ-002 Parameter INP_WORDS, default 4: number of input words that must be loaded before a run (1..16).
REQ-003 Parameter INS_WORDS, default 8: number of instruction words that must be loaded before a run (1..16).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 fetch_w / fetch_inp / fetch_ins / start  input  1 each  decoded DMA commands, level-sampled every cycle.
REQ-007 dma_address  input  4  target word address for the current fetch command.
REQ-008 data_in  input  8  write data accompanying a fetch command.
REQ-009 compute_done  input  1  one-cycle pulse from the array, meaning the run is finished.
REQ-010 w_we / inp_we / ins_we  output  1 each  write strobes to the weight, input and instruction memories.
REQ-011 wr_addr  output  4  registered write address shared by all memories.
REQ-012 wr_data  output  8  registered write data shared by all memories.
REQ-013 compute_start  output  1  one-cycle run-start pulse to the array.
REQ-014 busy  output  1  high while a run is in progress.
REQ-015 done  output  1  one-cycle pulse when a run completes.
REQ-016 err  output  1  sticky error flag (see Configuration).

Function
REQ-017 The FSM SHALL have the states IDLE, START, WAIT and FINISH.
REQ-018 In IDLE with fetch_X high, the block SHALL, on the next cycle, assert exactly one X_we for one cycle, with wr_addr=dma_address and wr_data=data_in as sampled. Latency is 1 cycle; one write per cycle while the command is held.
REQ-019 Each region SHALL keep a 16-bit written-mask. Every IDLE write sets bit dma_address; rewriting an already-set bit is legal.
REQ-020 Region X is complete when mask bits [X_WORDS-1:0] are all set. Bits at or above X_WORDS are written to memory but do not affect completeness.
REQ-021 If more than one command is high, priority SHALL be fetch_w > fetch_inp > fetch_ins > start; lower-priority commands are dropped that cycle.
REQ-022 With start high in IDLE and all three regions complete: IDLE->START, busy rises the next cycle, and compute_start is high for exactly the START cycle; then START->WAIT.
REQ-023 With start high in IDLE and any region incomplete, the block SHALL stay in IDLE and issue no compute_start.
REQ-024 In WAIT, compute_done SHALL move the FSM to FINISH; compute_done in any other state SHALL be ignored.
REQ-025 In FINISH: done is high for one cycle, all three masks clear, busy falls, and the FSM returns to IDLE.
REQ-026 Fetch commands in START, WAIT or FINISH SHALL produce no write strobe and SHALL NOT change any mask.
REQ-027 A start held high across FINISH->IDLE SHALL NOT relaunch, because the masks are now clear.

Reset
REQ-028 Asserting reset SHALL immediately force: state IDLE, all masks 0, all strobes 0, wr_addr=0, wr_data=0, compute_start=0, busy=0, done=0, err=0.
REQ-029 Reset during START or WAIT SHALL abort the run with no done pulse; a compute_done arriving after reset is ignored.

Configuration
REQ-030 With macro LOAD_SEQ_ERR_EN defined, err SHALL set and stay high until reset on any of:
  - a rejected start (REQ-023);
  - a fetch while not IDLE (REQ-026);
  - multiple commands high in the same cycle.
REQ-031 With LOAD_SEQ_ERR_EN undefined, err SHALL be tied 0 and all other behaviour SHALL be unchanged.

Verification
REQ-032 Load weights 0..3, inputs 0..3 and instructions 0..7 (data = addr+0x10), then start -> each write strobe appears 1 cycle after its command with matching addr/data; compute_start pulses once; busy=1.
REQ-033 Load only weights 0..2 plus inputs and instructions, then start -> no compute_start, busy=0; err=1 if LOAD_SEQ_ERR_EN is defined, else 0.
REQ-034 Complete run, compute_done in WAIT -> done pulses exactly 1 cycle, busy=0; an immediate second start is rejected (masks clear).
REQ-035 fetch_w with addr=5 during WAIT -> w_we stays 0 and the weight mask is unchanged; err=1 with the macro defined.
REQ-036 fetch_w and start high together in IDLE -> w_we is issued and no compute_start; err=1 with the macro defined.
REQ-037 Reset asserted mid-WAIT, then compute_done pulsed -> all outputs 0, no done, state IDLE, masks clear.
